sseg_scan_driver: RTL

- Multiplexed N-digit 7-segment display driver: hexadecimal decode plus time-multiplexed anode scanning, all outputs registered.
- Takes a packed hex value, a per-digit decimal-point mask and a per-digit blank mask, and drives shared cathodes and per-digit anodes, all active-low.
- Sits between the datapath/status logic and the board display pins.
- Value updates are double-buffered and applied only at frame boundaries, so no digit ever shows a mix of old and new data.

---
 rtl/sseg_scan_driver_pkg.sv | 32 +++
 rtl/sseg_scan_driver_hex_seg_lut.sv | 13 +
 rtl/sseg_scan_driver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sseg_scan_driver_pkg.sv
// sseg_pkg: shared constants and helpers for the multiplexed 7-segment driver.
//   SEG_TABLE  - hex nibble -> active-low segment code {a,b,c,d,e,f,g}
//   SEG_BLANK  - all segments dark
//   anode_off  - all-ones anode pattern for a given digit count
//   width_of   - counter width for a range of n values, never below 1
package sseg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] anode_off(input int digits);
    logic [MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_hex_seg_lut.sv
// hex_seg_lut: combinational hex nibble to active-low 7-segment code.
//   nibble_i  in  4  hex digit
//   seg_o     out 7  segments, bit6 = a ... bit0 = g, active-low
module hex_seg_lut
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed N-digit hex display driver.
// A LOAD captures VALUE/DP/BLANK into a shadow register; the shadow moves to
// the displayed (active) register only at a frame boundary, so a frame never
// mixes old and new data. All display outputs are registered.
//   CLK      in   system clock
//   RST      in   asynchronous active-high reset
//   LOAD     in   capture strobe for VALUE/DP/BLANK
//   VALUE    in   4*DIGITS packed nibbles, [3:0] = rightmost digit 0
//   DP       in   per-digit decimal point request, 1 = lit
//   BLANK    in   per-digit forced blank, 1 = dark
//   SSEG_CA  out  segment cathodes, active-low, bit6 = a ... bit0 = g
//   SSEG_DP  out  decimal-point cathode, active-low
//   SSEG_AN  out  digit anodes, active-low
//   FRAME    out  one-cycle pulse after each frame boundary
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     BLANK,
  output logic [6:0]            SSEG_CA,
  output logic                  SSEG_DP,
  output logic [DIGITS-1:0]     SSEG_AN,
  output logic                  FRAME
);

  localparam int IDX_W = width_of(DIGITS);
  localparam int PRE_W = width_of(REFRESH_DIV);
  localparam logic [MAX_DIGITS-1:0] AN_OFF_FULL = anode_off(DIGITS);
  localparam logic [DIGITS-1:0]     AN_OFF      = AN_OFF_FULL[DIGITS-1:0];
  localparam logic [PRE_W-1:0]      PRE_LAST    = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shd_val_q, act_val_q, act_val_d;
  logic [DIGITS-1:0]   shd_dp_q, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   shd_blank_q, act_blank_q, act_blank_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          ca_q, ca_d;
  logic                dp_q, dp_d;
  logic                frame_q, frame_d;

  logic                presc_wrap, frame_edge;
  logic [DIGITS-1:0]   lz_lead;
  logic [3:0]          nibble;
  logic [6:0]          seg_code;
  logic                dark;

  // Scan timing and double-buffer transfer.
  always_comb begin
    presc_wrap  = (presc_q == PRE_LAST);
    frame_edge  = presc_wrap && (idx_q == IDX_LAST);
    presc_d     = presc_wrap ? '0 : presc_q + PRE_W'(1);
    idx_d       = idx_q;
    if (presc_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    // The copy uses the pre-edge shadow, so a LOAD on the boundary edge
    // lands in the shadow and stays pending for the next frame.
    if (frame_edge && pending_q) begin
      act_val_d   = shd_val_q;
      act_dp_d    = shd_dp_q;
      act_blank_d = shd_blank_q;
    end
    pending_d = pending_q;
    if (LOAD)            pending_d = 1'b1;
    else if (frame_edge) pending_d = 1'b0;
    frame_d = frame_edge;
  end

  // lz_lead[k] = every active nibble from k up to the top digit is zero.
  always_comb begin
    logic zrun;
    zrun    = 1'b1;
    lz_lead = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zrun       = zrun & (act_val_q[4*k +: 4] == 4'h0);
      lz_lead[k] = zrun;
    end
  end

  assign nibble = act_val_q[{idx_q, 2'b00} +: 4];

  hex_seg_lut u_lut (
    .nibble_i (nibble),
    .seg_o    (seg_code)
  );

  always_comb begin
    dark = act_blank_q[idx_q] |
           ((LZ_BLANK != 0) && (idx_q != '0) && lz_lead[idx_q]);
    ca_d = dark ? SEG_BLANK : seg_code;
    dp_d = dark | ~act_dp_q[idx_q];
    // Prescaler 0 is a dead cycle so the anode switch never ghosts.
    an_d = AN_OFF;
    if (presc_q != '0) an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q     <= '0;
      idx_q       <= '0;
      shd_val_q   <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      pending_q   <= 1'b0;
      an_q        <= AN_OFF;
      ca_q        <= SEG_BLANK;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      if (LOAD) begin
        shd_val_q   <= VALUE;
        shd_dp_q    <= DP;
        shd_blank_q <= BLANK;
      end
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      ca_q        <= ca_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
    end
  end

  assign SSEG_CA = ca_q;
  assign SSEG_DP = dp_q;
  assign SSEG_AN = an_q;
  assign FRAME   = frame_q;

endmodule
